// File: rtl/usb_rx_path.sv
// ---------------------------------------------------------------------------
// usb_rx_path
//
// Receive-side datapath of the USB host. Samples the DP/DM lines once per
// clock (one bus bit time per cycle), NRZI-decodes, removes stuffed bits,
// recognises SYNC, PID and EOP, and optionally checks the DATA packet CRC16.
// The decoded handshake or DATA packet is handed to the protocol handler
// together with a set of status flags that are valid while rx_done pulses.
//
// Optional feature macro:
//   USB_RX_CRC16_CHECK_EN - when defined, the CRC16 residual checker is
//                           built and drives crc_error. When undefined,
//                           crc_error is tied to 0; the 16 CRC bits are
//                           still consumed and unstuffed.
//
// Parameters:
//   TIMEOUT_CYCLES - cycles allowed in WAIT_SYNC before a K must appear.
//
// Ports:
//   clock         in   system clock, one bus bit time per cycle
//   reset_n       in   asynchronous active-low reset
//   DP, DM        in   sampled bus lines (J=10, K=01, SE0=00, SE1=11)
//   rx_enable     in   arm receiver on rising edge; low aborts reception
//   rx_done       out  one-cycle pulse when reception ends (ok or error)
//   rx_pid        out  received PID nibble
//   rx_data       out  64-bit payload, first received byte in [7:0]
//   rx_has_data   out  packet was DATA0/DATA1 carrying 8 bytes
//   crc_error     out  CRC16 residual mismatch
//   pid_error     out  PID check nibble mismatch or unsupported PID
//   stuff_error   out  a 1 was seen where a stuffed 0 was required
//   format_error  out  bad SYNC, early SE0, any SE1, or malformed EOP
//   timeout       out  no SYNC start within TIMEOUT_CYCLES of arming
// ---------------------------------------------------------------------------
module usb_rx_path #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        DP,
    input  logic        DM,
    input  logic        rx_enable,
    output logic        rx_done,
    output logic [3:0]  rx_pid,
    output logic [63:0] rx_data,
    output logic        rx_has_data,
    output logic        crc_error,
    output logic        pid_error,
    output logic        stuff_error,
    output logic        format_error,
    output logic        timeout
);

    localparam int                   TIMEOUT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LOAD = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_ONE  = TIMEOUT_W'(1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_SYNC = 3'd1;
    localparam logic [2:0] ST_SYNC      = 3'd2;
    localparam logic [2:0] ST_PID       = 3'd3;
    localparam logic [2:0] ST_PAYLOAD   = 3'd4;
    localparam logic [2:0] ST_EOP       = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;

    localparam logic [6:0] SYNC_LAST    = 7'd6;
    localparam logic [6:0] PID_LAST     = 7'd7;
    localparam logic [6:0] DATA_LAST    = 7'd63;
    localparam logic [6:0] PAYLOAD_LAST = 7'd79;

    logic [2:0]           state;
    logic                 prev_j;
    logic                 rx_enable_q;
    logic [TIMEOUT_W-1:0] to_cnt;
    logic [6:0]           bit_cnt;
    logic [2:0]           ones_cnt;
    logic [1:0]           eop_cnt;
    logic [6:0]           pid_shift;

    logic       line_j;
    logic       line_k;
    logic       line_se0;
    logic       line_data;
    logic       dec_bit;
    logic       in_unstuff;
    logic       stuff_slot;
    logic       stuff_drop;
    logic       stuff_bad;
    logic       arm;
    logic       abort;
    logic [7:0] pid_byte;
    logic       pid_check_ok;

    assign line_j    = DP & ~DM;
    assign line_k    = ~DP & DM;
    assign line_se0  = ~DP & ~DM;
    assign line_data = line_j | line_k;

    // NRZI: no transition relative to the last J/K level means a 1.
    assign dec_bit = line_j ? prev_j : ~prev_j;

    // After six consecutive 1s the next data symbol is a stuffed bit: a 0
    // is silently dropped, a 1 is a stuffing violation.
    assign in_unstuff = (state == ST_PID) || (state == ST_PAYLOAD) || (state == ST_EOP);
    assign stuff_slot = (ones_cnt == 3'd6);
    assign stuff_drop = in_unstuff && line_data && stuff_slot && !dec_bit;
    assign stuff_bad  = in_unstuff && line_data && stuff_slot && dec_bit;

    assign arm   = (state == ST_IDLE) && rx_enable && !rx_enable_q;
    assign abort = (state != ST_IDLE) && !rx_enable;

    // The PID byte completes on its eighth bit, which is still on dec_bit.
    assign pid_byte     = {dec_bit, pid_shift};
    assign pid_check_ok = (pid_byte[7:4] == ~pid_byte[3:0]);

    assign rx_done = (state == ST_DONE) && rx_enable;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            prev_j       <= 1'b1;
            rx_enable_q  <= 1'b0;
            to_cnt       <= '0;
            bit_cnt      <= '0;
            ones_cnt     <= '0;
            eop_cnt      <= '0;
            pid_shift    <= '0;
            rx_pid       <= '0;
            rx_data      <= '0;
            rx_has_data  <= 1'b0;
            pid_error    <= 1'b0;
            stuff_error  <= 1'b0;
            format_error <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            rx_enable_q <= rx_enable;
            if (abort) begin
                // Dropping rx_enable discards the reception without a
                // rx_done pulse and leaves the flags in their cleared state.
                state        <= ST_IDLE;
                pid_error    <= 1'b0;
                stuff_error  <= 1'b0;
                format_error <= 1'b0;
                timeout      <= 1'b0;
            end else if (stuff_bad) begin
                stuff_error <= 1'b1;
                state       <= ST_DONE;
            end else if (stuff_drop) begin
                // Stuffed 0: updates the line level but no bit counter.
                prev_j   <= line_j;
                ones_cnt <= 3'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (arm) begin
                            state        <= ST_WAIT_SYNC;
                            to_cnt       <= TIMEOUT_LOAD;
                            prev_j       <= 1'b1;
                            rx_pid       <= '0;
                            rx_data      <= '0;
                            rx_has_data  <= 1'b0;
                            pid_error    <= 1'b0;
                            stuff_error  <= 1'b0;
                            format_error <= 1'b0;
                            timeout      <= 1'b0;
                        end
                    end

                    ST_WAIT_SYNC: begin
                        // The first K is the first SYNC bit (decoded 0).
                        if (line_k) begin
                            state   <= ST_SYNC;
                            prev_j  <= 1'b0;
                            bit_cnt <= '0;
                        end else if (to_cnt <= TIMEOUT_ONE) begin
                            timeout <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            to_cnt <= to_cnt - TIMEOUT_ONE;
                        end
                    end

                    ST_SYNC: begin
                        // Remaining seven SYNC bits must decode 0000001.
                        if (!line_data || (dec_bit != (bit_cnt == SYNC_LAST))) begin
                            format_error <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            prev_j <= line_j;
                            if (bit_cnt == SYNC_LAST) begin
                                state    <= ST_PID;
                                bit_cnt  <= '0;
                                ones_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                    end

                    ST_PID: begin
                        if (!line_data) begin
                            format_error <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            prev_j    <= line_j;
                            ones_cnt  <= dec_bit ? (ones_cnt + 3'd1) : 3'd0;
                            pid_shift <= {dec_bit, pid_shift[6:1]};
                            if (bit_cnt == PID_LAST) begin
                                bit_cnt <= '0;
                                rx_pid  <= pid_byte[3:0];
                                if (!pid_check_ok) begin
                                    pid_error <= 1'b1;
                                    state     <= ST_DONE;
                                end else begin
                                    case (pid_byte[3:0])
                                        PID_ACK, PID_NAK: begin
                                            state   <= ST_EOP;
                                            eop_cnt <= '0;
                                        end
                                        PID_DATA0, PID_DATA1: begin
                                            state <= ST_PAYLOAD;
                                        end
                                        default: begin
                                            pid_error <= 1'b1;
                                            state     <= ST_DONE;
                                        end
                                    endcase
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                    end

                    ST_PAYLOAD: begin
                        // 64 data bits shift in from the top so that the
                        // first received bit lands in rx_data[0]; the last
                        // 16 bits are the CRC and only feed the checker.
                        if (!line_data) begin
                            format_error <= 1'b1;
                            state        <= ST_DONE;
                        end else begin
                            prev_j   <= line_j;
                            ones_cnt <= dec_bit ? (ones_cnt + 3'd1) : 3'd0;
                            if (bit_cnt <= DATA_LAST) begin
                                rx_data <= {dec_bit, rx_data[63:1]};
                            end
                            if (bit_cnt == DATA_LAST) begin
                                rx_has_data <= 1'b1;
                            end
                            if (bit_cnt == PAYLOAD_LAST) begin
                                state   <= ST_EOP;
                                eop_cnt <= '0;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 7'd1;
                            end
                        end
                    end

                    ST_EOP: begin
                        // Expect SE0, SE0, J. A stuffed 0 right after the
                        // last CRC bit is absorbed by the unstuff path above.
                        if (eop_cnt != 2'd2) begin
                            if (line_se0) begin
                                eop_cnt  <= eop_cnt + 2'd1;
                                ones_cnt <= '0;
                            end else begin
                                format_error <= 1'b1;
                                state        <= ST_DONE;
                            end
                        end else begin
                            if (!line_j) begin
                                format_error <= 1'b1;
                            end
                            state <= ST_DONE;
                        end
                    end

                    ST_DONE: begin
                        state <= ST_IDLE;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef USB_RX_CRC16_CHECK_EN
    logic [15:0] crc_reg;
    logic [15:0] crc_next;
    logic        crc_fail;
    logic        payload_bit;

    // Unstuffed payload or CRC bit actually consumed this cycle.
    assign payload_bit = (state == ST_PAYLOAD) && line_data && !stuff_slot && !abort;

    // Serial CRC16 (x^16+x^15+x^2+1) in MSB-shift form; running it across
    // the data and the transmitted CRC leaves the fixed residual 16'h800D.
    assign crc_next = {crc_reg[14:0], 1'b0} ^ ((dec_bit ^ crc_reg[15]) ? 16'h8005 : 16'h0000);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_reg  <= 16'hFFFF;
            crc_fail <= 1'b0;
        end else if (arm || abort) begin
            crc_reg  <= 16'hFFFF;
            crc_fail <= 1'b0;
        end else if (payload_bit) begin
            crc_reg <= crc_next;
            if ((bit_cnt == PAYLOAD_LAST) && (crc_next != 16'h800D)) begin
                crc_fail <= 1'b1;
            end
        end
    end

    assign crc_error = crc_fail;
`else
    assign crc_error = 1'b0;
`endif

endmodule
